// File: rtl/row_scatter_pkg.sv
// Shared types and select-code map for the row register file.
// The row-read mux uses the same encoding, so both sides take it from here.
package row_scatter_pkg;

  localparam int NUM_ROWS = 10;
  localparam int SEL_W    = 4;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Code 7 is reserved by the read side, so rows 7..9 sit one code higher.
  localparam sel_t SEL_ROW0 = 4'd0;
  localparam sel_t SEL_ROW1 = 4'd1;
  localparam sel_t SEL_ROW2 = 4'd2;
  localparam sel_t SEL_ROW3 = 4'd3;
  localparam sel_t SEL_ROW4 = 4'd4;
  localparam sel_t SEL_ROW5 = 4'd5;
  localparam sel_t SEL_ROW6 = 4'd6;
  localparam sel_t SEL_ROW7 = 4'd8;
  localparam sel_t SEL_ROW8 = 4'd9;
  localparam sel_t SEL_ROW9 = 4'd10;

  localparam sel_t SEL_FIRST = SEL_ROW0;
  localparam sel_t SEL_LAST  = SEL_ROW9;

  function automatic sel_t sel_next(sel_t s);
    sel_t n;
    case (s)
      SEL_ROW6: n = SEL_ROW7;
      SEL_LAST: n = SEL_FIRST;
      default:  n = s + 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] sel2row(sel_t s);
    return (s > SEL_ROW6) ? s - 4'd1 : s;
  endfunction

endpackage

// File: rtl/row_scatter_if.sv
// Valid/ready input stream feeding the row scatter.
interface row_scatter_if #(parameter int DATA_WIDTH = 32) ();
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/row_scatter_sel_seq.sv
// Row select sequencer: walks the ten legal select codes, skipping 7.
module row_sel_seq
  import row_scatter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic adv_i,
  output sel_t sel_o,
  output logic last_o
);

  sel_t sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (clr_i)      sel_d = SEL_FIRST;
    else if (adv_i) sel_d = sel_next(sel_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= SEL_FIRST;
    else     sel_q <= sel_d;
  end

  assign sel_o  = sel_q;
  assign last_o = (sel_q == SEL_LAST);

endmodule

// File: rtl/row_scatter.sv
// Loads ten row registers from a valid/ready stream, one row per transfer,
// in select-code order, then pulses done.
module row_scatter
  import row_scatter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  start,
  row_scatter_if.slave          in_if,
  output logic [DATA_WIDTH-1:0] o0,
  output logic [DATA_WIDTH-1:0] o1,
  output logic [DATA_WIDTH-1:0] o2,
  output logic [DATA_WIDTH-1:0] o3,
  output logic [DATA_WIDTH-1:0] o4,
  output logic [DATA_WIDTH-1:0] o5,
  output logic [DATA_WIDTH-1:0] o6,
  output logic [DATA_WIDTH-1:0] o7,
  output logic [DATA_WIDTH-1:0] o8,
  output logic [DATA_WIDTH-1:0] o9,
  output logic [NUM_ROWS-1:0]   row_valid,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  busy,
  output logic                  done
);

  state_e                               state_q;
  logic                                 busy_q, done_q;
  logic [NUM_ROWS-1:0]                  row_valid_q;
  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  rows_q;
  logic [NUM_ROWS-1:0]                  wr_en;
  sel_t                                 sel;
  logic                                 sel_last;
  logic                                 sel_clr;
  logic                                 xfer;
  logic [3:0]                           wr_row;

  assign in_if.in_ready = (state_q == ST_LOAD) && ena;
  assign xfer           = in_if.in_ready && in_if.in_valid;
  assign sel_clr        = (state_q == ST_IDLE) && start && ena;
  assign wr_row         = sel2row(sel);

  row_sel_seq u_sel (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sel_clr),
    .adv_i  (xfer),
    .sel_o  (sel),
    .last_o (sel_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_valid_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && ena) begin
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
            row_valid_q <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            row_valid_q <= row_valid_q | wr_en;
            if (sel_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-hot write strobe keeps every other row untouched on a transfer edge.
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    assign wr_en[g] = xfer && (wr_row == 4'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          rows_q[g] <= '0;
      else if (wr_en[g]) rows_q[g] <= in_if.in_data;
    end
  end

  assign o0        = rows_q[0];
  assign o1        = rows_q[1];
  assign o2        = rows_q[2];
  assign o3        = rows_q[3];
  assign o4        = rows_q[4];
  assign o5        = rows_q[5];
  assign o6        = rows_q[6];
  assign o7        = rows_q[7];
  assign o8        = rows_q[8];
  assign o9        = rows_q[9];
  assign row_valid = row_valid_q;
  assign cur_sel   = sel;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_row_scatter.sv
// Scoreboard bench for row_scatter: driver feeds a reference model and queues
// per-cycle expectations; a negedge monitor compares them against the DUT.
module tb_row_scatter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst, ena, start;
  always #5 clk = ~clk;

  row_scatter_if #(.DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] o [10];
  logic [9:0]    row_valid;
  logic [3:0]    cur_sel;
  logic          busy, done;

  row_scatter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .in_if(bus),
    .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]), .o4(o[4]),
    .o5(o[5]), .o6(o[6]), .o7(o[7]), .o8(o[8]), .o9(o[9]),
    .row_valid(row_valid), .cur_sel(cur_sel), .busy(busy), .done(done)
  );

  typedef struct {
    int                   cyc;
    logic [9:0][DW-1:0]   rows;
    logic [9:0]           rv;
    logic [3:0]           sel;
    logic                 busy;
    logic                 done;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) edges <= edges + 1;

  // Reference model: a load is "rows written so far"; the select code is
  // simply looked up from that count.
  logic [3:0]         code_tbl [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
  bit                 m_load, m_done;
  int                 m_n;
  logic [9:0][DW-1:0] m_rows;
  logic [9:0]         m_rv;

  task automatic model_reset();
    m_load = 0; m_done = 0; m_n = 0; m_rows = '0; m_rv = '0;
  endtask

  task automatic model_edge(bit e, bit s, bit v, logic [DW-1:0] d);
    if (m_done) m_done = 0;
    else if (!m_load) begin
      if (s && e) begin m_load = 1; m_n = 0; m_rv = '0; end
    end else if (e && v) begin
      m_rows[m_n] = d;
      m_rv[m_n]   = 1'b1;
      m_n++;
      if (m_n == 10) begin m_load = 0; m_done = 1; m_n = 0; end
    end
  endtask

  function automatic exp_t snap(int c);
    exp_t x;
    x.cyc = c; x.rows = m_rows; x.rv = m_rv; x.sel = code_tbl[m_n];
    x.busy = m_load; x.done = m_done;
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, edges, act, exp);
  endtask

  task automatic step(bit r, bit e, bit s, bit v, logic [DW-1:0] d);
    @(posedge clk); #1;
    rst = r; ena = e; start = s; bus.in_valid = v; bus.in_data = d;
    if (r) begin
      // Reset takes effect now, so this cycle's expectation is replaced.
      if (sb.size() > 0 && sb[$].cyc == edges) void'(sb.pop_back());
      model_reset();
      sb.push_back(snap(edges));
    end else begin
      model_edge(e, s, v, d);
    end
    sb.push_back(snap(edges + 1));
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < edges) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].cyc == edges) begin
        x = sb.pop_front();
        for (int i = 0; i < 10; i++) chk($sformatf("o%0d", i), 64'(o[i]), 64'(x.rows[i]));
        chk("row_valid", 64'(row_valid), 64'(x.rv));
        chk("cur_sel",   64'(cur_sel),   64'(x.sel));
        chk("sel_legal", 64'(cur_sel != 4'd7 && cur_sel < 4'd11), 64'd1);
        chk("busy",      64'(busy),      64'(x.busy));
        chk("done",      64'(done),      64'(x.done));
        chk("in_ready",  64'(bus.in_ready), 64'(x.busy & ena));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; ena = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    model_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'hDEAD);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 32'h55);      // start with ena low is ignored

    // Full load 0x10..0x19, in_valid held high.
    step(0, 1, 1, 1, 32'hFF);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 32'h10 + i);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // ena drops for 3 cycles after 4 rows.
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 32'h20 + i);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'hBAD0 + i);
    for (int i = 4; i < 10; i++) step(0, 1, 0, 1, 32'h20 + i);
    step(0, 1, 0, 0, 0);

    // in_valid toggling.
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, bit'(i % 2), $urandom);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Reset after 6 rows; further data without start is ignored.
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 32'h30 + i);
    step(1, 1, 0, 1, 32'h99);
    step(0, 1, 0, 1, 32'h77);
    step(0, 1, 0, 1, 32'h78);

    // Start pulsed during LOAD and DONE, then a full reload 0xA0..0xA9.
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, bit'(i == 3), 1, 32'h40 + i);
    step(0, 1, 1, 1, 32'h5A);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 32'hA0 + i);
    step(0, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 149) == 0), bit'($urandom_range(0, 7) != 0),
           bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 3) != 0), $urandom);

    step(0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/row_scatter.md
ROW_SCATTER -- requirements
Module: row_scatter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of each data word and row register.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port ena  input  1  global enable; low freezes loading.
REQ-005 The block SHALL have port start  input  1  single-cycle pulse that begins a 10-row load.
REQ-006 The block SHALL have port in_data  input  DATA_WIDTH  incoming word.
REQ-007 The block SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 The block SHALL have ports o0..o9  output  DATA_WIDTH each  registered row contents, row N on oN.
REQ-010 The block SHALL have port row_valid  output  10  bit N set once row N is written in the current load.
REQ-011 The block SHALL have port cur_sel  output  4  select code of the next row to be written.
REQ-012 The block SHALL have port busy  output  1  high while in LOAD.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse after row 9 is written.

Function
REQ-014 The block SHALL map rows 0..9 to select codes 0,1,2,3,4,5,6,8,9,10 (code 7 skipped), matching the row-read select encoding.
REQ-015 cur_sel SHALL only ever take those ten codes; 7 and 11..15 are never produced.
REQ-016 The FSM SHALL have states IDLE, LOAD, DONE.
REQ-017 In IDLE: in_ready=0, busy=0; start=1 with ena=1 -> LOAD next cycle, cur_sel set to 0, row_valid cleared to 0.
REQ-018 start with ena=0 in IDLE SHALL be ignored.
REQ-019 In LOAD: in_ready=ena, busy=1.
REQ-020 A transfer SHALL occur on an edge where in_valid=1 and in_ready=1; in_data is written to the row addressed by cur_sel, its row_valid bit is set, cur_sel advances to the next code.
REQ-021 A written word SHALL appear on its oN output one cycle after the transfer edge (latency 1).
REQ-022 The transfer at cur_sel=10 SHALL move the FSM to DONE; cur_sel wraps to 0.
REQ-023 In DONE: done=1, in_ready=0, busy=0, for exactly one cycle, then IDLE unconditionally.
REQ-024 ena=0 during LOAD SHALL hold state, cur_sel, rows and row_valid; no transfer occurs even if in_valid=1.
REQ-025 start asserted in LOAD or DONE SHALL be ignored; no restart mid-load.
REQ-026 o0..o9 SHALL hold their values until overwritten; a new start does not clear them.
REQ-027 At most one row SHALL be written per cycle; no other row changes on that edge.

Reset
REQ-028 rst high SHALL asynchronously force state IDLE, cur_sel=0, o0..o9=0, row_valid=0, in_ready=0, busy=0, done=0.
REQ-029 rst asserted mid-LOAD SHALL abandon the load; after release the block waits in IDLE for a new start.

Structure
REQ-030 A shared package SHALL hold the FSM state type, NUM_ROWS=10 and the ten select-code constants, shared with the row-read mux.
REQ-031 One sub-module row_sel_seq SHALL generate cur_sel (clear, advance, last-code flag); the FSM and row registers stay in row_scatter.

Verification
REQ-032 Reset then start, in_valid held high with data 0x10..0x19 -> o0..o9 = 0x10..0x19, cur_sel sequence 0,1,2,3,4,5,6,8,9,10, done pulses once 11 cycles after start.
REQ-033 Mid-load (after 4 rows) drop ena for 3 cycles with in_valid=1 -> no writes, cur_sel stays 4, load resumes correctly on ena=1.
REQ-034 in_valid toggling every other cycle -> only valid cycles write; final rows correct; row_valid rises one bit per transfer.
REQ-035 Assert rst after 6 rows written -> all outputs 0 immediately; start needed to load again.
REQ-036 Pulse start during LOAD and again during DONE -> ignored; second full load with 0xA0..0xA9 overwrites all rows, row_valid cleared at start.
